// File: rtl/mantis_pkg.sv
// Shared widths and controller state encoding for the Mantis counter-mode front end.
package mantis_pkg;

    localparam int MANTIS_BLK_W = 64;
    localparam int MANTIS_TWK_W = 64;
    localparam int MANTIS_KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        RUN   = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/mantis_lat_timer.sv
// Down-counter that measures the core latency window once loaded.
// done is high when the count has reached zero; it is only meaningful
// while the owner is enabling the count after a load.
module mantis_lat_timer #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int W = $clog2(LAT + 1);

    logic [W-1:0] cnt_q;

    // Load the full latency, then count down to zero while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= W'(LAT);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/mantis_ctr_ctrl.sv
// Counter-mode controller for the Mantis core: the IV is encrypted under the
// message key with the block index as tweak, and the resulting keystream is
// XORed onto each incoming data block. One block is in flight at a time.
module mantis_ctr_ctrl
    import mantis_pkg::*;
#(
    parameter int CORE_LAT = 2,
    parameter int CTR_W    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MANTIS_KEY_W-1:0] key_in,
    input  logic [MANTIS_BLK_W-1:0] iv_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MANTIS_BLK_W-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [MANTIS_BLK_W-1:0] out_data,
    output logic                    out_last,
    output logic                    core_enc,
    output logic [MANTIS_KEY_W-1:0] core_K,
    output logic [MANTIS_BLK_W-1:0] core_P,
    output logic [MANTIS_TWK_W-1:0] core_T,
    input  logic [MANTIS_BLK_W-1:0] core_C,
    output logic                    busy,
    output logic                    ctr_err
);

    state_e                  state_q, state_d;
    logic [MANTIS_KEY_W-1:0] key_q, key_d;
    logic [MANTIS_BLK_W-1:0] iv_q, iv_d;
    logic [MANTIS_TWK_W-1:0] twk_q, twk_d;
    logic [CTR_W-1:0]        ctr_q, ctr_d;
    logic                    err_q, err_d;
    logic [MANTIS_BLK_W-1:0] data_q, data_d;
    logic                    last_q, last_d;
    logic [MANTIS_BLK_W-1:0] odata_q, odata_d;
    logic                    olast_q, olast_d;
    logic                    in_ready_c;
    logic                    timer_load;
    logic                    timer_done;

    // Counts the core latency from the cycle after a block is accepted.
    mantis_lat_timer #(
        .LAT (CORE_LAT)
    ) u_lat_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .en   (state_q == RUN),
        .done (timer_done)
    );

    // State and datapath registers; reset drops any in-flight block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            iv_q    <= '0;
            twk_q   <= '0;
            ctr_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            odata_q <= '0;
            olast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            iv_q    <= iv_d;
            twk_q   <= twk_d;
            ctr_q   <= ctr_d;
            err_q   <= err_d;
            data_q  <= data_d;
            last_q  <= last_d;
            odata_q <= odata_d;
            olast_q <= olast_d;
        end
    end

    // Next-state logic: message setup, block accept, keystream capture, output handshake.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        iv_d       = iv_q;
        twk_d      = twk_q;
        ctr_d      = ctr_q;
        err_d      = err_q;
        data_d     = data_q;
        last_d     = last_q;
        odata_d    = odata_q;
        olast_d    = olast_q;
        in_ready_c = 1'b0;
        timer_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    iv_d    = iv_in;
                    ctr_d   = '0;
                    err_d   = 1'b0;
                    state_d = READY;
                end
            end
            READY: begin
                in_ready_c = !err_q;
                // A new message wins over a block offered in the same cycle.
                if (start) begin
                    key_d = key_in;
                    iv_d  = iv_in;
                    ctr_d = '0;
                    err_d = 1'b0;
                end else if (in_valid && !err_q) begin
                    data_d             = in_data;
                    last_d             = in_last;
                    twk_d              = '0;
                    twk_d[CTR_W-1:0]   = ctr_q;
                    timer_load         = 1'b1;
                    state_d            = RUN;
                end
            end
            RUN: begin
                if (timer_done) begin
                    odata_d = core_C ^ data_q;
                    olast_d = last_q;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (olast_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = READY;
                        // An exhausted index must never be reused as a tweak.
                        if (ctr_q == {CTR_W{1'b1}}) begin
                            err_d = 1'b1;
                        end else begin
                            ctr_d = ctr_q + CTR_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = in_ready_c;
    assign out_valid = (state_q == OUT);
    assign out_data  = odata_q;
    assign out_last  = olast_q;
    assign core_enc  = 1'b1;
    assign core_K    = key_q;
    assign core_P    = iv_q;
    assign core_T    = twk_q;
    assign busy      = (state_q != IDLE);
    assign ctr_err   = err_q;

endmodule

// File: tb/tb_mantis_ctr_ctrl.sv
// Bench for mantis_ctr_ctrl with a stub core (C = P ^ T ^ K[63:0], CORE_LAT
// register stages). Expected keystream output is computed per block from the
// message key, IV and the block's position within its message.
module tb_mantis_ctr_ctrl;

    localparam int CORE_LAT = 2;
    localparam int CTR_W    = 2;
    localparam int IDX_MAX  = (1 << CTR_W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic [63:0]  iv_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [63:0]  out_data;
    logic         out_last;
    logic         core_enc;
    logic [127:0] core_K;
    logic [63:0]  core_P;
    logic [63:0]  core_T;
    logic [63:0]  core_C;
    logic         busy;
    logic         ctr_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model of the current message
    logic [127:0] m_key;
    logic [63:0]  m_iv;
    int           m_idx;
    logic         m_err;

    always #5 clk = ~clk;

    mantis_ctr_ctrl #(
        .CORE_LAT (CORE_LAT),
        .CTR_W    (CTR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .iv_in     (iv_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .core_enc  (core_enc),
        .core_K    (core_K),
        .core_P    (core_P),
        .core_T    (core_T),
        .core_C    (core_C),
        .busy      (busy),
        .ctr_err   (ctr_err)
    );

    // Stub core pipeline
    logic [63:0] pipe [CORE_LAT];
    always_ff @(posedge clk) begin
        pipe[0] <= core_P ^ core_T ^ core_K[63:0];
        for (int i = 1; i < CORE_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_C = pipe[CORE_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_out(input logic [63:0] data);
        return data ^ m_iv ^ 64'(m_idx) ^ m_key[63:0];
    endfunction

    task automatic do_start(input logic [127:0] key, input logic [63:0] iv);
        key_in = key;
        iv_in  = iv;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        m_key = key;
        m_iv  = iv;
        m_idx = 0;
        m_err = 1'b0;
        chk("start_K", core_K, key);
        chk("start_P", core_P, iv);
        chk("start_busy", busy, 1'b1);
        chk("start_ready", in_ready, 1'b1);
        chk("start_err", ctr_err, 1'b0);
    endtask

    // Offer a block and return once the accepting edge has passed
    task automatic accept_block(input logic [63:0] data, input logic last);
        int w;
        in_data  = data;
        in_last  = last;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        chk("accept_wait", 128'(w < 20), 128'(1));
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("core_T", core_T, 128'(m_idx));
        chk("ready_run", in_ready, 1'b0);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic send_block(input logic [63:0] data, input logic last, input int stall);
        int lat;
        logic [63:0] exp;
        accept_block(data, last);
        wait_out(lat);
        chk("latency", 128'(lat), 128'(CORE_LAT + 1));
        exp = model_out(data);
        chk("out_data", out_data, exp);
        chk("out_last", out_last, last);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, exp);
            chk("stall_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_valid", out_valid, 1'b0);
        if (last) begin
            chk("end_busy", busy, 1'b0);
            chk("end_ready", in_ready, 1'b0);
        end else begin
            if (m_idx == IDX_MAX) m_err = 1'b1;
            else m_idx++;
            chk("ctr_err", ctr_err, m_err);
            chk("next_ready", in_ready, !m_err);
        end
        $display("block data=%h last=%0d idx=%0d out=%h stall=%0d", data, last, m_idx, out_data, stall);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_ready"}, in_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_data"}, out_data, 64'd0);
        chk({tag, "_last"}, out_last, 1'b0);
        chk({tag, "_err"}, ctr_err, 1'b0);
        chk({tag, "_K"}, core_K, 128'd0);
        chk({tag, "_P"}, core_P, 64'd0);
        chk({tag, "_T"}, core_T, 64'd0);
    endtask

    initial begin
        int lat;
        logic [63:0] d;
        logic [63:0] exp;
        int len;

        // Reset with a block already offered
        in_valid = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk_reset_state("reset");
        chk("core_enc", core_enc, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_ready", in_ready, 1'b0);
            chk("idle_valid", out_valid, 1'b0);
            chk("idle_busy", busy, 1'b0);
        end
        in_valid = 1'b0;
        $display("reset/idle checked");

        // Single-block known answer
        do_start({64'h0, 64'h0F0F0F0F0F0F0F0F}, 64'h1111111111111111);
        send_block(64'h00000000000000FF, 1'b1, 0);
        chk("kat_data", out_data, 64'h1E1E1E1E1E1E1EE1);

        // Three-block message with a stall on block 1
        do_start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        send_block({$urandom, $urandom}, 1'b0, 0);
        send_block({$urandom, $urandom}, 1'b0, 5);
        send_block({$urandom, $urandom}, 1'b1, 0);

        // Counter exhaustion with a 2-bit index
        do_start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        for (int b = 0; b < 4; b++) send_block({$urandom, $urandom}, 1'b0, 0);
        chk("exhausted_err", ctr_err, 1'b1);
        in_data  = {$urandom, $urandom};
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("exh_ready", in_ready, 1'b0);
            chk("exh_valid", out_valid, 1'b0);
            chk("exh_T", core_T, 64'(IDX_MAX));
        end
        in_valid = 1'b0;
        $display("fifth block refused, ctr_err=%0d", ctr_err);
        do_start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        send_block({$urandom, $urandom}, 1'b1, 0);

        // start coincident with in_valid in READY
        do_start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        send_block({$urandom, $urandom}, 1'b0, 0);
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        iv_in    = {$urandom, $urandom};
        start    = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        m_key = key_in;
        m_iv  = iv_in;
        m_idx = 0;
        chk("coinc_P", core_P, m_iv);
        chk("coinc_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("coinc_valid", out_valid, 1'b0);
        end
        $display("start+in_valid: block dropped, new iv=%h", core_P);
        send_block({$urandom, $urandom}, 1'b1, 0);

        // start during RUN is ignored
        do_start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        d = {$urandom, $urandom};
        accept_block(d, 1'b1);
        key_in = {$urandom, $urandom, $urandom, $urandom};
        iv_in  = ~m_iv;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("run_start_P", core_P, m_iv);
        chk("run_start_K", core_K, m_key);
        wait_out(lat);
        exp = model_out(d);
        chk("run_start_data", out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("run_start_idle", busy, 1'b0);
        $display("start in RUN ignored, out=%h", exp);

        // Reset while in RUN
        do_start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        accept_block({$urandom, $urandom}, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("rst_run");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_run_stale", out_valid, 1'b0);
        end
        $display("reset in RUN checked");

        // Reset while in OUT
        do_start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        accept_block({$urandom, $urandom}, 1'b0);
        wait_out(lat);
        chk("rst_out_reach", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("rst_out");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_out_stale", out_valid, 1'b0);
        end
        $display("reset in OUT checked");

        // Randomized messages
        for (int m = 0; m < 8; m++) begin
            do_start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
            len = $urandom_range(1, IDX_MAX + 1);
            for (int b = 0; b < len; b++)
                send_block({$urandom, $urandom}, (b == len - 1), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
